// File: rtl/regfile_write_queue.sv
// regfile_write_queue: two-producer write buffer feeding the RegFile write port, with read bypass.
// Optional in-place coalescing of writes to pending non-head entries: define REGFILE_WQ_COALESCE_EN.
module regfile_write_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     a_valid,
    output logic                     a_ready,
    input  logic [AW-1:0]            a_addr,
    input  logic [DW-1:0]            a_data,
    input  logic                     b_valid,
    output logic                     b_ready,
    input  logic [AW-1:0]            b_addr,
    input  logic [DW-1:0]            b_data,
    output logic                     we,
    output logic [AW-1:0]            wa,
    output logic [DW-1:0]            wd,
    input  logic [AW-1:0]            ra1,
    input  logic [AW-1:0]            ra2,
    output logic                     hit1,
    output logic                     hit2,
    output logic [DW-1:0]            bd1,
    output logic [DW-1:0]            bd2,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0] addr_q [DEPTH];
    logic [AW-1:0] addr_d [DEPTH];
    logic [DW-1:0] data_q [DEPTH];
    logic [DW-1:0] data_d [DEPTH];
    logic [PW-1:0] head_q, head_d, tail, a_idx, b_idx;
    logic [CW-1:0] count_q, count_d, free;
    logic          pop, a_acc, b_acc, a_hit, b_hit, same, a_enq, b_enq;

    // Handshake readiness and drain port; free space ignores the same-cycle pop.
    always_comb begin
        free    = CW'(DEPTH) - count_q;
        a_ready = free >= CW'(1);
        b_ready = (free >= CW'(2)) || ((free >= CW'(1)) && !a_valid);
        pop     = count_q != '0;
        we      = pop;
        wa      = pop ? addr_q[head_q] : '0;
        wd      = pop ? data_q[head_q] : '0;
        count   = count_q;
    end

    // Bypass lookups scan oldest to newest so the newest match wins.
    always_comb begin
        hit1 = 1'b0;
        hit2 = 1'b0;
        bd1  = '0;
        bd2  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (i < int'(count_q) && ra1 != '0 && addr_q[head_q + PW'(i)] == ra1) begin
                hit1 = 1'b1;
                bd1  = data_q[head_q + PW'(i)];
            end
            if (i < int'(count_q) && ra2 != '0 && addr_q[head_q + PW'(i)] == ra2) begin
                hit2 = 1'b1;
                bd2  = data_q[head_q + PW'(i)];
            end
        end
    end

    // Next queue contents: A lands before B; register 0 writes are swallowed.
    always_comb begin
        a_acc = a_valid && a_ready && a_addr != '0;
        b_acc = b_valid && b_ready && b_addr != '0;
        a_hit = 1'b0;
        b_hit = 1'b0;
        a_idx = '0;
        b_idx = '0;
        same  = 1'b0;
`ifdef REGFILE_WQ_COALESCE_EN
        for (int i = 1; i < DEPTH; i++) begin
            if (i < int'(count_q) && addr_q[head_q + PW'(i)] == a_addr) begin
                a_hit = 1'b1;
                a_idx = head_q + PW'(i);
            end
            if (i < int'(count_q) && addr_q[head_q + PW'(i)] == b_addr) begin
                b_hit = 1'b1;
                b_idx = head_q + PW'(i);
            end
        end
        same = a_acc && b_acc && a_addr == b_addr;
`endif
        a_enq  = a_acc && !a_hit && !same;
        b_enq  = b_acc && !b_hit;
        tail   = head_q + count_q[PW-1:0];
        addr_d = addr_q;
        data_d = data_q;
        if (a_acc && a_hit) data_d[a_idx] = a_data;
        if (b_acc && b_hit) data_d[b_idx] = b_data;
        if (a_enq) begin
            addr_d[tail] = a_addr;
            data_d[tail] = a_data;
        end
        if (b_enq) begin
            addr_d[tail + PW'(a_enq)] = b_addr;
            data_d[tail + PW'(a_enq)] = b_data;
        end
        head_d  = head_q + PW'(pop);
        count_d = count_q + CW'(a_enq) + CW'(b_enq) - CW'(pop);
    end

    // Queue state registers; reset discards everything pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q  <= '{default: '0};
            data_q  <= '{default: '0};
            head_q  <= '0;
            count_q <= '0;
        end else begin
            addr_q  <= addr_d;
            data_q  <= data_d;
            head_q  <= head_d;
            count_q <= count_d;
        end
    end
endmodule

// File: tb/tb_regfile_write_queue.sv
// tb_regfile_write_queue: randomized and directed checks against a queue-based reference model.
module tb_regfile_write_queue;
    localparam int DEPTH = 4;
    localparam int AW    = 5;
    localparam int DW    = 32;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } ent_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          a_valid = 1'b0, b_valid = 1'b0;
    logic          a_ready, b_ready, we, hit1, hit2;
    logic [AW-1:0] a_addr = '0, b_addr = '0, ra1 = '0, ra2 = '0, wa;
    logic [DW-1:0] a_data = '0, b_data = '0, wd, bd1, bd2;
    logic [$clog2(DEPTH):0] count;

    ent_t          q[$];
    logic          m_ar, m_br;
    logic [DW-1:0] rf_dut [32];
    int            total = 0;
    int            bad = 0;

    regfile_write_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
        .we(we), .wa(wa), .wd(wd),
        .ra1(ra1), .ra2(ra2), .hit1(hit1), .hit2(hit2), .bd1(bd1), .bd2(bd2),
        .count(count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (we) rf_dut[wa] <= wd;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic lookup(input logic [AW-1:0] ra, output logic h, output logic [DW-1:0] d);
        h = 1'b0;
        d = '0;
        if (ra != 0) foreach (q[i]) if (q[i].addr == ra) begin
            h = 1'b1;
            d = q[i].data;
        end
    endtask

    task automatic compare_all();
        int fr;
        logic h;
        logic [DW-1:0] d;
        fr   = DEPTH - q.size();
        m_ar = fr >= 1;
        m_br = fr >= 2 || (fr >= 1 && !a_valid);
        check("a_ready", a_ready, m_ar);
        check("b_ready", b_ready, m_br);
        check("we", we, q.size() != 0);
        check("wa", wa, q.size() != 0 ? q[0].addr : 0);
        check("wd", wd, q.size() != 0 ? q[0].data : 0);
        check("count", count, q.size());
        lookup(ra1, h, d);
        check("hit1", hit1, h);
        check("bd1", bd1, d);
        lookup(ra2, h, d);
        check("hit2", hit2, h);
        check("bd2", bd2, d);
    endtask

    function automatic int find_nonhead(input logic [AW-1:0] ad);
        int j = -1;
        for (int i = 1; i < q.size(); i++) if (q[i].addr == ad) j = i;
        return j;
    endfunction

    task automatic model_update();
        ent_t push[$];
        logic ia, ib;
        int j;
        ia = a_valid && m_ar && a_addr != 0;
        ib = b_valid && m_br && b_addr != 0;
`ifdef REGFILE_WQ_COALESCE_EN
        if (ia) begin
            j = find_nonhead(a_addr);
            if (j > 0) q[j].data = a_data;
            else push.push_back({a_addr, a_data});
        end
        if (ib) begin
            j = find_nonhead(b_addr);
            if (j > 0) q[j].data = b_data;
            else if (push.size() > 0 && push[0].addr == b_addr) push[0].data = b_data;
            else push.push_back({b_addr, b_data});
        end
`else
        j = 0;
        if (ia) push.push_back({a_addr, a_data});
        if (ib) push.push_back({b_addr, b_data});
`endif
        if (q.size() > 0) q.delete(0);
        foreach (push[i]) q.push_back(push[i]);
    endtask

    task automatic drive(input logic av, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                         input logic bv, input logic [AW-1:0] ba, input logic [DW-1:0] bdat,
                         input logic [AW-1:0] r1, input logic [AW-1:0] r2);
        a_valid = av; a_addr = aa; a_data = ad;
        b_valid = bv; b_addr = ba; b_data = bdat;
        ra1 = r1; ra2 = r2;
    endtask

    task automatic cycle(input logic av, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                         input logic bv, input logic [AW-1:0] ba, input logic [DW-1:0] bdat,
                         input logic [AW-1:0] r1, input logic [AW-1:0] r2);
        drive(av, aa, ad, bv, ba, bdat, r1, r2);
        #1 compare_all();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        #1;
        check("rst_we", we, 0);
        check("rst_count", count, 0);
        check("rst_wd", wd, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        cycle(1, 0, 32'hFFFFFFFF, 0, 0, 0, 0, 0);
        check("r0_count", count, 0);
        check("r0_we", we, 0);
        check("r0_hit1", hit1, 0);

        cycle(1, 5, 32'hDEADBEEF, 0, 0, 0, 5, 0);
        check("a_we", we, 1);
        check("a_wa", wa, 5);
        check("a_wd", wd, 32'hDEADBEEF);
        check("a_hit1", hit1, 1);
        idle(1);
        check("a_rf5", rf_dut[5], 32'hDEADBEEF);

        cycle(1, 3, 32'h11111111, 1, 4, 32'h22222222, 0, 0);
        check("dual_cnt2", count, 2);
        check("dual_wa3", wa, 3);
        idle(1);
        check("dual_cnt1", count, 1);
        check("dual_wd4", wd, 32'h22222222);
        idle(1);
        check("dual_cnt0", count, 0);

        cycle(1, 1, 32'h1, 1, 2, 32'h2, 0, 0);
        cycle(1, 3, 32'h3, 1, 4, 32'h4, 0, 0);
        check("bp_cnt3", count, 3);
        drive(1, 6, 32'h6, 1, 8, 32'h8, 0, 0);
        #1 compare_all();
        check("bp_a_ready", a_ready, 1);
        check("bp_b_ready", b_ready, 0);
        @(posedge clk);
        model_update();
        @(negedge clk);
        idle(4);

        cycle(1, 1, 32'h1, 1, 2, 32'h2, 0, 0);
        cycle(1, 3, 32'h3, 1, 4, 32'h4, 0, 0);
        check("mid_cnt3", count, 3);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_we", we, 0);
        check("mid_rst_count", count, 0);
        check("mid_rst_wd", wd, 0);
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);

        cycle(1, 1, 32'h12345678, 1, 7, 32'hAAAA0000, 0, 7);
        cycle(1, 7, 32'hBBBB0000, 0, 0, 0, 0, 7);
        check("byp_hit2", hit2, 1);
        check("byp_bd2", bd2, 32'hBBBB0000);
`ifdef REGFILE_WQ_COALESCE_EN
        check("byp_count", count, 1);
`else
        check("byp_count", count, 2);
`endif
        idle(4);

        for (int n = 0; n < 400; n++)
            cycle($urandom_range(0, 1), AW'($urandom_range(0, 7)), $urandom,
                  $urandom_range(0, 1), AW'($urandom_range(0, 7)), $urandom,
                  AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)));
        idle(6);
        check("end_count", count, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
